// File: rtl/mul_result_unloader.sv
// rtl/mul_result_unloader.sv - operand latch, product capture and byte-serial unload around the 8x8 multiplier
//
// Purpose: latches two 8-bit operands from the system bus and drives them into
// the external combinational multiplier. On START it captures the 16-bit
// product, then offers it back on the 8-bit bus, low byte first, one byte per
// RD. It also keeps zero and overflow flags for the flags register.
//
// Ports:
//   CLK      in   system clock, rising edge
//   CLR      in   synchronous active-high reset
//   BUS_IN   in   [7:0]  bus data for operand loads
//   LOAD_A   in   latch BUS_IN into operand A (only when idle)
//   LOAD_B   in   latch BUS_IN into operand B (only when idle)
//   START    in   request product capture (only when idle)
//   RD       in   consume the byte on BUS_OUT
//   MUL_A    out  [7:0]  operand A to multiplier
//   MUL_B    out  [7:0]  operand B to multiplier
//   MUL_P    in   [15:0] multiplier product
//   BUS_OUT  out  [7:0]  offered product byte, 0 when not valid
//   VALID    out  BUS_OUT holds a product byte
//   HI_SEL   out  0 = low byte offered, 1 = high byte offered
//   BUSY     out  unit is not idle
//   ZERO     out  last captured product was zero
//   OVF      out  last captured product exceeded 255
//
// Build option: MUL_OVF_FLAG_EN - when defined, OVF is registered at capture;
// when undefined, OVF is constant 0.

module mul_result_unloader (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [7:0]  BUS_IN,
    input  logic        LOAD_A,
    input  logic        LOAD_B,
    input  logic        START,
    input  logic        RD,
    output logic [7:0]  MUL_A,
    output logic [7:0]  MUL_B,
    input  logic [15:0] MUL_P,
    output logic [7:0]  BUS_OUT,
    output logic        VALID,
    output logic        HI_SEL,
    output logic        BUSY,
    output logic        ZERO,
    output logic        OVF
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        OUT_LO  = 2'd2,
        OUT_HI  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] p;

    // All outputs are registers updated alongside the state so that they
    // change exactly at the edge that moves the state.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= IDLE;
            MUL_A   <= 8'h00;
            MUL_B   <= 8'h00;
            p       <= 16'h0000;
            BUS_OUT <= 8'h00;
            VALID   <= 1'b0;
            HI_SEL  <= 1'b0;
            BUSY    <= 1'b0;
            ZERO    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Both loads together square the bus value.
                    if (LOAD_A) MUL_A <= BUS_IN;
                    if (LOAD_B) MUL_B <= BUS_IN;
                    if (START) begin
                        state <= CAPTURE;
                        BUSY  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    p       <= MUL_P;
                    ZERO    <= (MUL_P == 16'h0000);
                    BUS_OUT <= MUL_P[7:0];
                    VALID   <= 1'b1;
                    HI_SEL  <= 1'b0;
                    state   <= OUT_LO;
                end
                OUT_LO: begin
                    if (RD) begin
                        BUS_OUT <= p[15:8];
                        HI_SEL  <= 1'b1;
                        state   <= OUT_HI;
                    end
                end
                OUT_HI: begin
                    if (RD) begin
                        BUS_OUT <= 8'h00;
                        VALID   <= 1'b0;
                        HI_SEL  <= 1'b0;
                        BUSY    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            ovf_q <= 1'b0;
        end else if (state == CAPTURE) begin
            ovf_q <= (MUL_P[15:8] != 8'h00);
        end
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_mul_result_unloader.sv
// tb/tb_mul_result_unloader.sv - directed self-checking bench for mul_result_unloader

module tb_mul_result_unloader;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [7:0]  BUS_IN = 8'h00;
    logic        LOAD_A = 1'b0;
    logic        LOAD_B = 1'b0;
    logic        START = 1'b0;
    logic        RD = 1'b0;
    logic [7:0]  MUL_A;
    logic [7:0]  MUL_B;
    logic [15:0] MUL_P;
    logic [7:0]  BUS_OUT;
    logic        VALID;
    logic        HI_SEL;
    logic        BUSY;
    logic        ZERO;
    logic        OVF;

    int checks = 0;
    int errors = 0;

`ifdef MUL_OVF_FLAG_EN
    localparam logic OVF_BIG = 1'b1;
`else
    localparam logic OVF_BIG = 1'b0;
`endif

    // Behavioural stand-in for the combinational multiplier.
    assign MUL_P = 16'(MUL_A) * 16'(MUL_B);

    always #5 CLK = ~CLK;

    mul_result_unloader dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .BUS_IN  (BUS_IN),
        .LOAD_A  (LOAD_A),
        .LOAD_B  (LOAD_B),
        .START   (START),
        .RD      (RD),
        .MUL_A   (MUL_A),
        .MUL_B   (MUL_B),
        .MUL_P   (MUL_P),
        .BUS_OUT (BUS_OUT),
        .VALID   (VALID),
        .HI_SEL  (HI_SEL),
        .BUSY    (BUSY),
        .ZERO    (ZERO),
        .OVF     (OVF)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] b, input logic v,
                             input logic h, input logic bz);
        check({tag, " bus"}, 16'(BUS_OUT), 16'(b));
        check({tag, " valid"}, 16'(VALID), 16'(v));
        check({tag, " hi_sel"}, 16'(HI_SEL), 16'(h));
        check({tag, " busy"}, 16'(BUSY), 16'(bz));
    endtask

    initial begin
        // Reset
        CLR = 1'b1; tick(); CLR = 1'b0;
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset mul_a", 16'(MUL_A), 16'h0);
        check("reset mul_b", 16'(MUL_B), 16'h0);
        check("reset zero", 16'(ZERO), 16'h0);
        check("reset ovf", 16'(OVF), 16'h0);

        // 13 * 11 = 143 = 0x008F
        BUS_IN = 8'd13; LOAD_A = 1'b1; tick(); LOAD_A = 1'b0;
        BUS_IN = 8'd11; LOAD_B = 1'b1; tick(); LOAD_B = 1'b0;
        check("t1 mul_a", 16'(MUL_A), 16'd13);
        check("t1 mul_b", 16'(MUL_B), 16'd11);
        START = 1'b1; tick(); START = 1'b0;
        check_out("t1 capture", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("t1 lo", 8'h8F, 1'b1, 1'b0, 1'b1);
        check("t1 zero", 16'(ZERO), 16'h0);
        check("t1 ovf", 16'(OVF), 16'h0);
        RD = 1'b1; tick();
        check_out("t1 hi", 8'h00, 1'b1, 1'b1, 1'b1);
        tick(); RD = 1'b0;
        check_out("t1 done", 8'h00, 1'b0, 1'b0, 1'b0);

        // 255 * 255 = 0xFE01
        BUS_IN = 8'd255; LOAD_A = 1'b1; LOAD_B = 1'b1; tick();
        LOAD_A = 1'b0; LOAD_B = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        tick();
        check_out("t2 lo", 8'h01, 1'b1, 1'b0, 1'b1);
        check("t2 ovf", 16'(OVF), 16'(OVF_BIG));
        RD = 1'b1; tick();
        check_out("t2 hi", 8'hFE, 1'b1, 1'b1, 1'b1);
        tick(); RD = 1'b0;
        check_out("t2 done", 8'h00, 1'b0, 1'b0, 1'b0);
        check("t2 ovf hold", 16'(OVF), 16'(OVF_BIG));

        // 0 * 200 = 0
        BUS_IN = 8'd0; LOAD_A = 1'b1; tick(); LOAD_A = 1'b0;
        BUS_IN = 8'd200; LOAD_B = 1'b1; tick(); LOAD_B = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        tick();
        check_out("t3 lo", 8'h00, 1'b1, 1'b0, 1'b1);
        check("t3 zero", 16'(ZERO), 16'h1);
        check("t3 ovf", 16'(OVF), 16'h0);
        RD = 1'b1; tick();
        check_out("t3 hi", 8'h00, 1'b1, 1'b1, 1'b1);
        tick(); RD = 1'b0;
        check("t3 zero hold", 16'(ZERO), 16'h1);

        // 3 * 4 = 0x0C; ZERO clears at capture
        BUS_IN = 8'd3; LOAD_A = 1'b1; tick(); LOAD_A = 1'b0;
        BUS_IN = 8'd4; LOAD_B = 1'b1; tick(); LOAD_B = 1'b0;
        START = 1'b1; tick(); START = 1'b0;
        check("t4 zero in capture", 16'(ZERO), 16'h1);
        tick();
        check("t4 zero", 16'(ZERO), 16'h0);
        check_out("t4 lo", 8'h0C, 1'b1, 1'b0, 1'b1);

        // Loads and START ignored while busy
        START = 1'b1; LOAD_A = 1'b1; BUS_IN = 8'd99; RD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("t5 hold", 8'h0C, 1'b1, 1'b0, 1'b1);
            check("t5 mul_a", 16'(MUL_A), 16'd3);
        end
        START = 1'b0; LOAD_A = 1'b0;
        RD = 1'b1; tick(); RD = 1'b0;
        check_out("t5 hi", 8'h00, 1'b1, 1'b1, 1'b1);

        // CLR mid-unload discards the product
        CLR = 1'b1; tick(); CLR = 1'b0;
        check_out("t6 clr", 8'h00, 1'b0, 1'b0, 1'b0);
        check("t6 mul_a", 16'(MUL_A), 16'h0);
        check("t6 mul_b", 16'(MUL_B), 16'h0);
        check("t6 zero", 16'(ZERO), 16'h0);
        check("t6 ovf", 16'(OVF), 16'h0);
        RD = 1'b1; tick(); tick(); RD = 1'b0;
        check_out("t6 rd idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Square-load with START in the same cycle: 16 * 16 = 0x0100
        BUS_IN = 8'd16; LOAD_A = 1'b1; LOAD_B = 1'b1; START = 1'b1; tick();
        LOAD_A = 1'b0; LOAD_B = 1'b0; START = 1'b0;
        check_out("t7 capture", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("t7 lo", 8'h00, 1'b1, 1'b0, 1'b1);
        check("t7 zero", 16'(ZERO), 16'h0);
        check("t7 ovf", 16'(OVF), 16'(OVF_BIG));
        RD = 1'b1; tick();
        check_out("t7 hi", 8'h01, 1'b1, 1'b1, 1'b1);
        tick(); RD = 1'b0;
        check_out("t7 done", 8'h00, 1'b0, 1'b0, 1'b0);

        // Back-to-back START right after the high byte is consumed: 16*16 again
        START = 1'b1; tick(); START = 1'b0;
        check("t8 busy", 16'(BUSY), 16'h1);
        tick();
        check_out("t8 lo", 8'h00, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
